// File: rtl/afe_spi_pkg.sv
// Shared types and constants for the AFE attenuator SPI writer.
// Optional shadow readback is enabled with AFE_SPI_SHADOW_EN.
package afe_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      LE_SETUP,
      LE_PULSE,
      LE_HOLD
   } state_e;

   localparam int BUSY_BIT    = 31;
   localparam int OVERRUN_BIT = 30;
   localparam int CLEAR_BIT   = 31;
   localparam int CHANNEL_BIT = 24;

   // sysClk cycles per SPI half period, rounded up so SPI_RATE is never exceeded.
   function automatic int unsigned calc_half(input int unsigned clk_rate,
                                             input int unsigned spi_rate);
      int unsigned h;
      h = (clk_rate + 2 * spi_rate - 1) / (2 * spi_rate);
      return (h < 1) ? 1 : h;
   endfunction

endpackage

// File: rtl/afe_spi_attenuator_writer_half_tick.sv
// Restartable divider: one-cycle tick every HALF sysClk cycles.
module spi_half_tick #(
   parameter int unsigned HALF = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      tick = !restart && (cnt_q == LAST);
      if (restart || (cnt_q == LAST)) cnt_d = '0;
      else                            cnt_d = cnt_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/afe_spi_attenuator_writer.sv
// Write-only SPI driver for the AFE attenuator/switch shift registers.
// Define AFE_SPI_SHADOW_EN to read back the last latched word per channel.
module afe_spi_attenuator_writer
   import afe_spi_pkg::*;
#(
   parameter int unsigned CLK_RATE      = 99999001,
   parameter int unsigned SPI_RATE      = 1000000,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned CHANNEL_COUNT = 2
) (
   input  logic                     sysClk,
   input  logic                     sysReset,
   input  logic                     csrStrobe,
   input  logic [31:0]              GPIO_OUT,
   output logic [31:0]              status,
   output logic [CHANNEL_COUNT-1:0] AFE_SPI_CLK,
   output logic [CHANNEL_COUNT-1:0] AFE_SPI_SDI,
   output logic [CHANNEL_COUNT-1:0] AFE_SPI_LE
);

   localparam int unsigned HALF  = calc_half(CLK_RATE, SPI_RATE);
   localparam int          BIT_W = $clog2(DATA_WIDTH + 1);

   state_e                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    overrun_q, overrun_d;
   logic                    ch_q, ch_d;
   logic [DATA_WIDTH-1:0]   sr_q, sr_d;
   logic [BIT_W-1:0]        bits_q, bits_d;
   logic                    sclk_q, sclk_d;
   logic                    sdi_q, sdi_d;
   logic                    le_q, le_d;
   logic [CHANNEL_COUNT-1:0] clk_pins_q, clk_pins_d;
   logic [CHANNEL_COUNT-1:0] sdi_pins_q, sdi_pins_d;
   logic [CHANNEL_COUNT-1:0] le_pins_q, le_pins_d;

   logic tick;
   logic clear_cmd;
   logic write_cmd;
   logic unused_gpio;

   assign clear_cmd   = csrStrobe && GPIO_OUT[CLEAR_BIT];
   assign write_cmd   = csrStrobe && !GPIO_OUT[CLEAR_BIT];
   assign unused_gpio = ^GPIO_OUT;

   spi_half_tick #(.HALF(HALF)) u_half_tick (
      .clk     (sysClk),
      .rst     (sysReset),
      .restart (state_q == IDLE),
      .tick    (tick)
   );

`ifdef AFE_SPI_SHADOW_EN
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] shadow_q [CHANNEL_COUNT];
   logic [DATA_WIDTH-1:0] shadow_d [CHANNEL_COUNT];
   logic [DATA_WIDTH-1:0] shadow_sel;
`endif

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      overrun_d = overrun_q;
      ch_d      = ch_q;
      sr_d      = sr_q;
      bits_d    = bits_q;
      sclk_d    = sclk_q;
      sdi_d     = sdi_q;
      le_d      = le_q;
`ifdef AFE_SPI_SHADOW_EN
      data_d    = data_q;
`endif

      // A clear always wins; a write that arrives while busy only flags overrun.
      if (clear_cmd)                           overrun_d = 1'b0;
      else if (write_cmd && state_q != IDLE)   overrun_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (write_cmd) begin
               state_d = SHIFT_LO;
               busy_d  = 1'b1;
               ch_d    = (CHANNEL_COUNT > 1) ? GPIO_OUT[CHANNEL_BIT] : 1'b0;
               sdi_d   = GPIO_OUT[DATA_WIDTH-1];
               sr_d    = GPIO_OUT[DATA_WIDTH-1:0] << 1;
               bits_d  = BIT_W'(DATA_WIDTH - 1);
`ifdef AFE_SPI_SHADOW_EN
               data_d  = GPIO_OUT[DATA_WIDTH-1:0];
`endif
            end
         end
         SHIFT_LO: begin
            if (tick) begin
               state_d = SHIFT_HI;
               sclk_d  = 1'b1;
            end
         end
         SHIFT_HI: begin
            if (tick) begin
               sclk_d = 1'b0;
               if (bits_q != '0) begin
                  sdi_d   = sr_q[DATA_WIDTH-1];
                  sr_d    = sr_q << 1;
                  bits_d  = bits_q - 1'b1;
                  state_d = SHIFT_LO;
               end else begin
                  sdi_d   = 1'b0;
                  state_d = LE_SETUP;
               end
            end
         end
         LE_SETUP: begin
            if (tick) begin
               state_d = LE_PULSE;
               le_d    = 1'b1;
            end
         end
         LE_PULSE: begin
            if (tick) begin
               state_d = LE_HOLD;
               le_d    = 1'b0;
            end
         end
         LE_HOLD: begin
            if (tick) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Only the selected chain sees activity; the other stays parked low.
      for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
         clk_pins_d[c] = sclk_d && (ch_d == 1'(c));
         sdi_pins_d[c] = sdi_d  && (ch_d == 1'(c));
         le_pins_d[c]  = le_d   && (ch_d == 1'(c));
      end
   end

   always_ff @(posedge sysClk or posedge sysReset) begin
      if (sysReset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         ch_q       <= 1'b0;
         sr_q       <= '0;
         bits_q     <= '0;
         sclk_q     <= 1'b0;
         sdi_q      <= 1'b0;
         le_q       <= 1'b0;
         clk_pins_q <= '0;
         sdi_pins_q <= '0;
         le_pins_q  <= '0;
`ifdef AFE_SPI_SHADOW_EN
         data_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
         ch_q       <= ch_d;
         sr_q       <= sr_d;
         bits_q     <= bits_d;
         sclk_q     <= sclk_d;
         sdi_q      <= sdi_d;
         le_q       <= le_d;
         clk_pins_q <= clk_pins_d;
         sdi_pins_q <= sdi_pins_d;
         le_pins_q  <= le_pins_d;
`ifdef AFE_SPI_SHADOW_EN
         data_q     <= data_d;
`endif
      end
   end

`ifdef AFE_SPI_SHADOW_EN
   always_comb begin
      shadow_sel = '0;
      for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
         shadow_d[c] = shadow_q[c];
         if (state_q == LE_SETUP && tick && ch_q == 1'(c)) shadow_d[c] = data_q;
         if (ch_q == 1'(c)) shadow_sel = shadow_q[c];
      end
   end

   // NOTE: the shadow array is architecturally visible after reset, so it is reset like any flop.
   always_ff @(posedge sysClk or posedge sysReset) begin
      if (sysReset) begin
         for (int c = 0; c < int'(CHANNEL_COUNT); c++) shadow_q[c] <= '0;
      end else begin
         for (int c = 0; c < int'(CHANNEL_COUNT); c++) shadow_q[c] <= shadow_d[c];
      end
   end
`endif

   always_comb begin
      status              = '0;
      status[BUSY_BIT]    = busy_q;
      status[OVERRUN_BIT] = overrun_q;
`ifdef AFE_SPI_SHADOW_EN
      status[DATA_WIDTH-1:0] = shadow_sel;
`endif
   end

   assign AFE_SPI_CLK = clk_pins_q;
   assign AFE_SPI_SDI = sdi_pins_q;
   assign AFE_SPI_LE  = le_pins_q;

endmodule

// File: tb/tb_afe_spi_attenuator_writer.sv
// Directed bench for afe_spi_attenuator_writer with HALF=2, 8-bit words, two chains.
// Shadow checks follow AFE_SPI_SHADOW_EN when the bench is compiled with it.
module tb_afe_spi_attenuator_writer;

   logic        sysClk = 1'b0;
   logic        sysReset = 1'b1;
   logic        csrStrobe = 1'b0;
   logic [31:0] GPIO_OUT = '0;
   logic [31:0] status;
   logic [1:0]  spi_clk, spi_sdi, spi_le;

   afe_spi_attenuator_writer #(
      .CLK_RATE(8), .SPI_RATE(2), .DATA_WIDTH(8), .CHANNEL_COUNT(2)
   ) dut (
      .sysClk      (sysClk),
      .sysReset    (sysReset),
      .csrStrobe   (csrStrobe),
      .GPIO_OUT    (GPIO_OUT),
      .status      (status),
      .AFE_SPI_CLK (spi_clk),
      .AFE_SPI_SDI (spi_sdi),
      .AFE_SPI_LE  (spi_le)
   );

   always #5 sysClk = ~sysClk;

   // Pin monitor: sampled on the falling edge, away from the active edge.
   int          rises [2]     = '{0, 0};
   int          le_cyc [2]    = '{0, 0};
   int          le_pulses [2] = '{0, 0};
   int          act [2]       = '{0, 0};
   logic [31:0] rx [2]        = '{32'h0, 32'h0};
   int          busy_cyc      = 0;
   int          setup_err     = 0;
   logic [1:0]  prev_clk = '0, prev_le = '0, prev_sdi = '0;

   always @(negedge sysClk) begin
      for (int c = 0; c < 2; c++) begin
         if (spi_clk[c] && !prev_clk[c]) begin
            rises[c]++;
            rx[c] = {rx[c][30:0], spi_sdi[c]};
         end
         if (spi_clk[c] && prev_clk[c] && spi_sdi[c] != prev_sdi[c]) setup_err++;
         if (spi_le[c]) le_cyc[c]++;
         if (spi_le[c] && !prev_le[c]) le_pulses[c]++;
         if (spi_clk[c] || spi_sdi[c] || spi_le[c]) act[c]++;
      end
      if (status[31]) busy_cyc++;
      prev_clk = spi_clk;
      prev_le  = spi_le;
      prev_sdi = spi_sdi;
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_total++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
   endtask

   task automatic do_write(input logic [31:0] w);
      @(posedge sysClk);
      #1;
      csrStrobe = 1'b1;
      GPIO_OUT  = w;
      @(posedge sysClk);
      #1;
      csrStrobe = 1'b0;
      GPIO_OUT  = '0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (status[31] && n < 200) begin
         @(negedge sysClk);
         n++;
      end
      if (n >= 200) check({name, "_idle_timeout"}, {31'h0, status[31]}, 32'h0);
      repeat (3) @(negedge sysClk);
   endtask

   typedef struct {
      string       name;
      logic [31:0] word;
      int          ch;
      logic [7:0]  dat;
      int          exp_rises;
      int          exp_le_cyc;
      int          exp_busy;
   } vec_t;

   vec_t vecs [5];

   int base_rises [2], base_le [2], base_pul [2], base_act [2], base_busy;

   task automatic snap();
      for (int c = 0; c < 2; c++) begin
         base_rises[c] = rises[c];
         base_le[c]    = le_cyc[c];
         base_pul[c]   = le_pulses[c];
         base_act[c]   = act[c];
      end
      base_busy = busy_cyc;
   endtask

   logic [7:0] shadow_exp;

   initial begin
      vecs[0] = '{"a5_ch0",    32'h0000_00A5, 0, 8'hA5, 8, 2, 38};
      vecs[1] = '{"3c_ch1",    32'h0100_003C, 1, 8'h3C, 8, 2, 38};
      vecs[2] = '{"01_ch0",    32'h0000_0001, 0, 8'h01, 8, 2, 38};
      vecs[3] = '{"80_ch1",    32'h0100_0080, 1, 8'h80, 8, 2, 38};
      vecs[4] = '{"hi_ignore", 32'h00FF_FF00, 0, 8'h00, 8, 2, 38};

      repeat (2) @(negedge sysClk);
      check("reset_status", status, 32'h0);
      check("reset_pins", {26'h0, spi_clk, spi_sdi, spi_le}, 32'h0);
      sysReset = 1'b0;
      repeat (2) @(negedge sysClk);

      for (int i = 0; i < 5; i++) begin
         int oc;
         oc = 1 - vecs[i].ch;
         snap();
         do_write(vecs[i].word);
         check({vecs[i].name, "_busy_set"}, {31'h0, status[31]}, 32'h1);
         wait_idle(vecs[i].name);
         check({vecs[i].name, "_data"}, {24'h0, rx[vecs[i].ch][7:0]}, {24'h0, vecs[i].dat});
         check({vecs[i].name, "_rises"}, rises[vecs[i].ch] - base_rises[vecs[i].ch], vecs[i].exp_rises);
         check({vecs[i].name, "_le_width"}, le_cyc[vecs[i].ch] - base_le[vecs[i].ch], vecs[i].exp_le_cyc);
         check({vecs[i].name, "_le_pulses"}, le_pulses[vecs[i].ch] - base_pul[vecs[i].ch], 1);
         check({vecs[i].name, "_busy_cycles"}, busy_cyc - base_busy, vecs[i].exp_busy);
         check({vecs[i].name, "_other_idle"}, act[oc] - base_act[oc], 0);
         check({vecs[i].name, "_status_hi"}, {30'h0, status[31:30]}, 32'h0);
      end

      // Write while busy: ignored, overrun set; clear command afterwards.
      snap();
      do_write(32'h0000_00FF);
      repeat (5) @(posedge sysClk);
      do_write(32'h0000_0012);
      check("ovr_set", {31'h0, status[30]}, 32'h1);
      wait_idle("ovr");
      check("ovr_data", {24'h0, rx[0][7:0]}, 32'h0000_00FF);
      check("ovr_rises", rises[0] - base_rises[0], 8);
      check("ovr_le_pulses", le_pulses[0] - base_pul[0], 1);
      check("ovr_sticky", {31'h0, status[30]}, 32'h1);
      snap();
      do_write(32'h8000_0000);
      check("clr_status", status, 32'h0);
      repeat (10) @(negedge sysClk);
      check("clr_no_spi", (act[0] - base_act[0]) + (act[1] - base_act[1]), 0);
      check("clr_no_busy", busy_cyc - base_busy, 0);

      // Clear command issued while a transfer is running.
      snap();
      do_write(32'h0100_0011);
      repeat (3) @(posedge sysClk);
      do_write(32'h0000_0022);
      check("busy_ovr_set", {31'h0, status[30]}, 32'h1);
      do_write(32'h8000_0000);
      check("busy_clr", {30'h0, status[31:30]}, 32'h2);
      wait_idle("busy_clr");
      check("busy_clr_stays", {31'h0, status[30]}, 32'h0);
      check("busy_clr_data", {24'h0, rx[1][7:0]}, 32'h0000_0011);
      check("busy_clr_rises", rises[1] - base_rises[1], 8);

      // Reset 20 cycles into a transfer.
      snap();
      do_write(32'h0000_00A5);
      repeat (20) @(negedge sysClk);
      sysReset = 1'b1;
      #1;
      check("rst_mid_pins", {26'h0, spi_clk, spi_sdi, spi_le}, 32'h0);
      check("rst_mid_status", status, 32'h0);
      repeat (2) @(negedge sysClk);
      sysReset = 1'b0;
      repeat (3) @(negedge sysClk);
      check("rst_mid_no_le", (le_pulses[0] - base_pul[0]) + (le_pulses[1] - base_pul[1]), 0);
      snap();
      do_write(32'h0000_0001);
      wait_idle("post_rst");
      check("post_rst_data", {24'h0, rx[0][7:0]}, 32'h0000_0001);
      check("post_rst_rises", rises[0] - base_rises[0], 8);
      check("post_rst_le", le_pulses[0] - base_pul[0], 1);

      // Shadow readback (zero when the feature is compiled out).
      do_write(32'h0000_005A);
      wait_idle("sh0");
      do_write(32'h0100_0033);
      wait_idle("sh1");
`ifdef AFE_SPI_SHADOW_EN
      shadow_exp = 8'h33;
`else
      shadow_exp = 8'h00;
`endif
      check("shadow_ch1", {24'h0, status[7:0]}, {24'h0, shadow_exp});
      do_write(32'h0000_005A);
      wait_idle("sh2");
`ifdef AFE_SPI_SHADOW_EN
      shadow_exp = 8'h5A;
`else
      shadow_exp = 8'h00;
`endif
      check("shadow_ch0", {24'h0, status[7:0]}, {24'h0, shadow_exp});

      check("sdi_setup", setup_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/afe_spi_attenuator_writer.md
Name: afe_spi_attenuator_writer

Overview:
- Write-only serial driver for the two AFE attenuator/switch shift registers.
- Drives the top-level AFE_SPI_CLK, AFE_SPI_SDI and AFE_SPI_LE pins.
- Takes one CSR write from the system-clock GPIO bus, shifts the word MSB-first to the selected AFE, then pulses that AFE's latch enable.
- Exposes busy/overrun status for firmware polling.

Parameters:
- CLK_RATE, 99999001, sysClk frequency in Hz.
- SPI_RATE, 1000000, maximum SPI clock frequency in Hz.
- DATA_WIDTH, 8, bits per AFE transfer (1..24).
- CHANNEL_COUNT, 2, number of AFE chains (1..2).

Ports:
- sysClk  in  1  system clock; all logic is in this domain.
- sysReset  in  1  asynchronous, active-high reset.
- csrStrobe  in  1  single-cycle write strobe.
- GPIO_OUT  in  32  write word: [DATA_WIDTH-1:0] data, [24] channel select, [31] clear-overrun command.
- status  out  32  [31] busy, [30] overrun, [DATA_WIDTH-1:0] shadow (only with the optional feature), others 0.
- AFE_SPI_CLK  out  CHANNEL_COUNT  serial clock per chain, idle low.
- AFE_SPI_SDI  out  CHANNEL_COUNT  serial data per chain, idle low.
- AFE_SPI_LE  out  CHANNEL_COUNT  latch enable per chain, idle low.

Behaviour:
- Reset:
  - All outputs 0; status = 0; state IDLE; divider = 0.
  - Reset asserted mid-transfer aborts immediately: pins go low the same cycle (async). No partial latch pulse may ever appear.
- Divider: HALF = (CLK_RATE + 2*SPI_RATE - 1)/(2*SPI_RATE), clamped to a minimum of 1 (defaults give 50). One "half" = HALF sysClk cycles.
- States: IDLE, SHIFT_LO, SHIFT_HI, LE_SETUP, LE_PULSE, LE_HOLD.
- IDLE:
  - csrStrobe with GPIO_OUT[31]=1 clears overrun only; no transfer.
  - Otherwise, latch data and channel select (select ≥ CHANNEL_COUNT maps to channel 0).
  - Next cycle: busy=1, SDI = MSB, go to SHIFT_LO.
- Shifting:
  - SHIFT_LO: CLK low for one half, then SHIFT_HI.
  - SHIFT_HI: CLK high for one half.
  - At the end of SHIFT_HI: if bits remain, shift the next bit onto SDI and go to SHIFT_LO. If it was the last bit, force SDI low and go to LE_SETUP.
  - SDI changes only while CLK is low or on the cycle CLK falls, so setup time is at least one half.
- Latch:
  - LE_SETUP: one half, CLK and LE low.
  - LE_PULSE: LE high for one half.
  - LE_HOLD: one half low, then IDLE; busy=0 on IDLE entry.
- Total busy time: (2*DATA_WIDTH+3)*HALF cycles. The unselected channel's pins stay low throughout.
- csrStrobe while busy:
  - Data is ignored and overrun is set (sticky).
  - A clear command while busy clears overrun and does not set it.
- csrStrobe on the same cycle busy falls counts as busy (ignored, overrun set).
- Overrun stays set until a clear command or reset.

Optional Feature:
- Macro AFE_SPI_SHADOW_EN.
- Defined:
  - One DATA_WIDTH shadow register per channel, reset to 0.
  - A channel's shadow updates with its data at LE_PULSE entry.
  - status[DATA_WIDTH-1:0] returns the shadow of the channel selected by the most recent accepted write.
- Not defined: no shadow storage; those status bits read 0.

Decomposition:
- Package afe_spi_pkg:
  - state enum.
  - Status bit indices BUSY_BIT=31, OVERRUN_BIT=30.
  - CLEAR_BIT=31, CHANNEL_BIT=24.
  - HALF computation function.
- One sub-module, spi_half_tick: divider producing a one-cycle tick every HALF cycles, restartable on transfer start.

Test Plan:
- Bench with CLK_RATE=8, SPI_RATE=2 (HALF=2), DATA_WIDTH=8.
- Write 0x000000A5 -> channel 0 SDI samples at CLK rises read 1,0,1,0,0,1,0,1; exactly 8 CLK pulses; one LE pulse 2 cycles wide; busy high 38 cycles; channel 1 pins stay 0.
- Write 0x0100003C -> the same sequence on channel 1 only, serializing 0x3C; channel 0 idle.
- Write 0x000000FF, then a second write 5 cycles later -> second write ignored, overrun=1, only 8 clocks; then write 0x80000000 -> overrun=0, no SPI activity.
- Assert sysReset 20 cycles into a transfer -> all pins 0 that cycle, status=0, no LE pulse; a later write 0x00000001 completes normally.
- With AFE_SPI_SHADOW_EN, write 0x0000005A to ch0 and 0x01000033 to ch1 -> status[7:0]=0x33; re-write ch0 0x5A -> status[7:0]=0x5A. Without the macro, status[7:0] stays 0.
